// File: rtl/deglitch_pkg.sv
// Shared types and constants for the multi-channel input deglitcher.
// Latency: n/a (package only).
// Backpressure: n/a; DEGLITCH_GLITCH_CNT_EN enables the per-channel glitch counters.
package deglitch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } chan_state_e;

    localparam int GLITCH_CNT_W = 8;
    localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = {GLITCH_CNT_W{1'b1}};

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 8;

    function automatic logic [GLITCH_CNT_W-1:0] glitch_sat_inc(input logic [GLITCH_CNT_W-1:0] v);
        return (v == GLITCH_CNT_MAX) ? v : v + {{(GLITCH_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/deglitch_chan.sv
// One deglitch channel: synchroniser, IDLE/QUAL qualifier, edge pulses, optional glitch counter (DEGLITCH_GLITCH_CNT_EN).
// Latency: SYNC_STAGES + dly + 2 clocks from the sampling edge to out.
// Backpressure: none; free-running, every clock is consumed.
module deglitch_chan
    import deglitch_pkg::*;
#(
    parameter int   SYNC_STAGES = 3,
    parameter int   COUNT_WIDTH = 16,
    parameter logic RESET_BIT   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   in,
    input  logic [COUNT_WIDTH-1:0] rise_dly,
    input  logic [COUNT_WIDTH-1:0] fall_dly,
    output logic                   out,
    output logic                   rise_pulse,
    output logic                   fall_pulse,
    output logic                   busy
`ifdef DEGLITCH_GLITCH_CNT_EN
    ,
    input  logic                    glitch_clr,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("deglitch_chan: SYNC_STAGES out of range");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    chan_state_e            state_q;
    chan_state_e            state_d;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [COUNT_WIDTH-1:0] cnt_d;
    logic                   out_q;
    logic                   out_d;
    logic                   rise_pulse_q;
    logic                   rise_pulse_d;
    logic                   fall_pulse_q;
    logic                   fall_pulse_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], in};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_d        = out_q;
        rise_pulse_d = 1'b0;
        fall_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s != out_q) begin
                    cnt_d   = s ? rise_dly : fall_dly;
                    state_d = QUAL;
                end
            end
            QUAL: begin
                if (s == out_q) begin
                    // Input went back before qualifying: drop the attempt silently.
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    out_d        = s;
                    rise_pulse_d = s;
                    fall_pulse_d = ~s;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync_q       <= {SYNC_STAGES{RESET_BIT}};
            state_q      <= IDLE;
            cnt_q        <= '0;
            out_q        <= RESET_BIT;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
        end
    end

    assign out        = out_q;
    assign rise_pulse = rise_pulse_q;
    assign fall_pulse = fall_pulse_q;
    assign busy       = (state_q == QUAL);

`ifdef DEGLITCH_GLITCH_CNT_EN
    logic                    glitch_abort;
    logic [GLITCH_CNT_W-1:0] glitch_cnt_q;
    logic [GLITCH_CNT_W-1:0] glitch_cnt_d;

    assign glitch_abort = (state_q == QUAL) && (s == out_q);

    // Clear takes priority so software never loses a clear to a racing glitch.
    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (glitch_clr) begin
            glitch_cnt_d = '0;
        end else if (glitch_abort) begin
            glitch_cnt_d = glitch_sat_inc(glitch_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: rtl/multi_deglitch.sv
// CHANNELS independent synchronise-and-qualify filters for slow board inputs; DEGLITCH_GLITCH_CNT_EN adds glitch counters.
// Latency: SYNC_STAGES + dly + 2 clocks per channel; busy is combinational from channel state.
// Backpressure: none; free-running.
module multi_deglitch
    import deglitch_pkg::*;
#(
    parameter int                  CHANNELS    = 8,
    parameter int                  SYNC_STAGES = 3,
    parameter int                  COUNT_WIDTH = 16,
    parameter logic [CHANNELS-1:0] RESET_VAL   = {CHANNELS{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic [CHANNELS-1:0]    in,
    input  logic [COUNT_WIDTH-1:0] rise_dly,
    input  logic [COUNT_WIDTH-1:0] fall_dly,
    output logic [CHANNELS-1:0]    out,
    output logic [CHANNELS-1:0]    rise_pulse,
    output logic [CHANNELS-1:0]    fall_pulse,
    output logic                   busy
`ifdef DEGLITCH_GLITCH_CNT_EN
    ,
    input  logic                             glitch_clr,
    output logic [CHANNELS*GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    logic [CHANNELS-1:0] chan_busy;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        deglitch_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .COUNT_WIDTH (COUNT_WIDTH),
            .RESET_BIT   (RESET_VAL[i])
        ) u_chan (
            .clk        (clk),
            .rst_l      (rst_l),
            .in         (in[i]),
            .rise_dly   (rise_dly),
            .fall_dly   (fall_dly),
            .out        (out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .busy       (chan_busy[i])
`ifdef DEGLITCH_GLITCH_CNT_EN
            ,
            .glitch_clr (glitch_clr),
            .glitch_cnt (glitch_cnt[GLITCH_CNT_W*i +: GLITCH_CNT_W])
`endif
        );
    end

    assign busy = |chan_busy;

endmodule

// File: doc/multi_deglitch.md
Name: multi_deglitch

Overview:
- Multi-channel synchroniser plus qualification filter for slow board-level inputs (button, presence, PGOOD, alert lines) entering the CPLD.
- Generalises the single-channel fixed-delay deglitcher:
  - N channels.
  - Configurable synchroniser depth.
  - Separate runtime rise/fall qualification times.
  - Per-channel edge pulses and a busy flag.
- Sits between I/O pads and the I2C register/control logic.

Parameters:
- CHANNELS, 8: number of independent input channels (1..32).
- SYNC_STAGES, 3: synchroniser flops per channel (legal 2..8).
- COUNT_WIDTH, 16: width of qualification counter and delay inputs.
- RESET_VAL, all ones (CHANNELS bits): per-channel reset value of sync chain and out.

Ports:
- clk  in  1  system clock.
- rst_l  in  1  reset; asynchronous, active-low.
- in  in  CHANNELS  raw asynchronous inputs.
- rise_dly  in  COUNT_WIDTH  qualification time for 0->1, in clocks; quasi-static, shared by all channels.
- fall_dly  in  COUNT_WIDTH  qualification time for 1->0, in clocks; quasi-static, shared by all channels.
- out  out  CHANNELS  filtered levels.
- rise_pulse  out  CHANNELS  one-cycle strobe when out goes 0->1.
- fall_pulse  out  CHANNELS  one-cycle strobe when out goes 1->0.
- busy  out  1  OR of all channels in QUAL state.

Behaviour:
- Reset values:
  - Sync chain bit i and out[i] = RESET_VAL[i].
  - Pulses = 0, busy = 0, counters = 0, all channels in IDLE.
- Synchroniser: in[i] shifts through SYNC_STAGES flops; s[i] is the last stage.
- Per-channel FSM, states IDLE and QUAL:
  - IDLE, s == out: stay.
  - IDLE, s != out: load cnt = (s ? rise_dly : fall_dly); go to QUAL.
  - QUAL, s == out (glitch): abort to IDLE; out unchanged; no pulse.
  - QUAL, s != out, cnt != 0: cnt <= cnt - 1.
  - QUAL, s != out, cnt == 0: out <= s; assert matching pulse for exactly one cycle (registered, same edge as out); go to IDLE.
- Latency: an input held stable reaches out SYNC_STAGES + dly + 2 clocks after the first clk edge that samples it.
- Pulse and glitch rules:
  - A mismatch lasting <= dly+1 cycles produces no output change.
  - dly = 0 gives the minimum latency.
- Delay inputs are sampled only at load. Changing rise_dly/fall_dly mid-QUAL does not affect the running count.
- Counter never wraps: it decrements only while nonzero, and the terminal check happens at 0.
- Channels are fully independent. Simultaneous events on any channels are legal.
- busy is combinational from the state registers: asserted the cycle after entry to QUAL, deasserted the cycle after exit.
- Async reset mid-QUAL: immediately returns out to RESET_VAL, clears pulses, and discards the count.

Optional Feature:
- Macro DEGLITCH_GLITCH_CNT_EN.
- When defined, adds these ports:
  - glitch_clr  in  1.
  - glitch_cnt  out  CHANNELS*8: channel i at bits [8i+7:8i].
- Counter behaviour when defined:
  - Per-channel 8-bit counter increments on each QUAL abort.
  - Saturates at 255.
  - Synchronously cleared by glitch_clr; clear wins over a same-cycle increment.
  - Reset value 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package deglitch_pkg holds:
  - State enum (IDLE = 0, QUAL = 1).
  - Glitch counter width constant (8) and saturation value.
  - Legal-range constants for SYNC_STAGES.
- Sub-module deglitch_chan: one channel (sync chain, FSM, counter, pulses, optional glitch counter).
- multi_deglitch generates CHANNELS instances and ORs busy.

Test Plan:
- Reset: hold rst_l low with in = 0.
  - out = RESET_VAL, pulses 0, busy 0.
  - After release with in = 0 and fall_dly = 10, out[0] falls 3+10+2 = 15 clocks later, with one fall_pulse[0].
- Rise qualification: rise_dly = 100, in[2] 0->1 held.
  - out[2] rises exactly SYNC_STAGES + 102 clocks after the sampling edge.
  - rise_pulse[2] is high for one cycle; busy spans the QUAL window.
- Glitch rejection: rise_dly = 20; in[1] pulses high for 15 clocks, then 21 clocks.
  - out[1] stays 0; no pulses.
  - With the macro defined, glitch_cnt[1] = 2.
- Asymmetric/zero delay: rise_dly = 0, fall_dly = 50, toggle in[5].
  - Rise latency SYNC_STAGES+2; fall latency SYNC_STAGES+52.
  - Change fall_dly to 5 mid-QUAL: the running count still uses 50.
- Simultaneous events: all CHANNELS toggle on the same edge.
  - All out bits and pulses update on the same cycle; busy drops one cycle after.
  - Assert rst_l low mid-QUAL: outputs return to RESET_VAL immediately.
- Saturation/clear (macro): inject 300 glitches on channel 0.
  - glitch_cnt[0] = 255.
  - glitch_clr together with a glitch abort in the same cycle leaves the count at 0.
